// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee vending slice: drink codes, customer FSM states,
// default prices and timing.
package coffee_pkg;

   typedef enum logic [1:0] {
      D_NONE = 2'b00,
      D_ES   = 2'b01,
      D_ESL  = 2'b10,
      D_CAP  = 2'b11
   } drink_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COIN,
      S_GAP,
      S_WAIT,
      S_DONE
   } state_t;

   // Prices in 0.5-unit coins
   localparam int DEF_P_ES    = 2;
   localparam int DEF_P_ESL   = 3;
   localparam int DEF_P_CAP   = 4;
   localparam int DEF_GAP     = 2;
   localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/coffee_customer_tx_if.sv
// Order/coin/dispense signal bundle between the customer initiator and its environment.
interface coffee_customer_tx_if;

   logic       start;
   logic [1:0] drink;
   logic       es;
   logic       esl;
   logic       cap;
   logic       c05;
   logic       c10;
   logic [1:0] sel;
   logic       busy;
   logic       done;
   logic       ok;
   logic       tmo;

   modport master (
      input  start, drink, es, esl, cap,
      output c05, c10, sel, busy, done, ok, tmo
   );

   modport slave (
      output start, drink, es, esl, cap,
      input  c05, c10, sel, busy, done, ok, tmo
   );

endinterface

// File: rtl/coffee_down_timer.sv
// Loadable down counter that stops at zero; used for both coin gaps and the dispense timeout.
module coffee_down_timer #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         tick,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (tick && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/coffee_customer_tx.sv
// Customer-side initiator: pays for one drink with greedy c10/c05 pulses, presents the
// selection, then waits for the dispense output and reports ok/timeout.
module coffee_customer_tx
   import coffee_pkg::*;
#(
   parameter int GAP     = DEF_GAP,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int P_ES    = DEF_P_ES,
   parameter int P_ESL   = DEF_P_ESL,
   parameter int P_CAP   = DEF_P_CAP
) (
   input logic                 clock,
   input logic                 reset,
   coffee_customer_tx_if.master bus
);

   localparam int TMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   // Loading N-1 and leaving on zero gives exactly N cycles in the state.
   localparam logic [TW-1:0] GAP_LD  = TW'(GAP - 1);
   localparam logic [TW-1:0] TOUT_LD = TW'(TIMEOUT - 1);

   state_t       state, state_nxt;
   drink_t       drink_q, drink_nxt;
   logic [3:0]   rem, rem_nxt;
   logic         ok_q, ok_nxt, tmo_q, tmo_nxt;
   logic         t_load, t_tick, t_zero;
   logic [TW-1:0] t_val;
   logic         req_hit, oth_hit;

   function automatic logic [3:0] price(input logic [1:0] d);
      case (d)
         D_ES:    price = 4'(P_ES);
         D_ESL:   price = 4'(P_ESL);
         D_CAP:   price = 4'(P_CAP);
         default: price = 4'd0;
      endcase
   endfunction

   coffee_down_timer #(.W(TW)) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (t_load),
      .value (t_val),
      .tick  (t_tick),
      .zero  (t_zero)
   );

   assign req_hit = (drink_q == D_ES  && bus.es)  ||
                    (drink_q == D_ESL && bus.esl) ||
                    (drink_q == D_CAP && bus.cap);
   assign oth_hit = (drink_q != D_ES  && bus.es)  ||
                    (drink_q != D_ESL && bus.esl) ||
                    (drink_q != D_CAP && bus.cap);

   always_comb begin
      state_nxt = state;
      drink_nxt = drink_q;
      rem_nxt   = rem;
      ok_nxt    = ok_q;
      tmo_nxt   = tmo_q;
      t_load    = 1'b0;
      t_tick    = 1'b0;
      t_val     = '0;
      case (state)
         S_IDLE: begin
            if (bus.start && (bus.drink != D_NONE)) begin
               state_nxt = S_COIN;
               drink_nxt = drink_t'(bus.drink);
               rem_nxt   = price(bus.drink);
               ok_nxt    = 1'b0;
               tmo_nxt   = 1'b0;
            end
         end
         S_COIN: begin
            state_nxt = S_GAP;
            t_load    = 1'b1;
            t_val     = GAP_LD;
            if (rem >= 4'd2)      rem_nxt = rem - 4'd2;
            else if (rem != 4'd0) rem_nxt = rem - 4'd1;
         end
         S_GAP: begin
            if (!t_zero) begin
               t_tick = 1'b1;
            end else if (rem == 4'd0) begin
               state_nxt = S_WAIT;
               t_load    = 1'b1;
               t_val     = TOUT_LD;
            end else begin
               state_nxt = S_COIN;
            end
         end
         S_WAIT: begin
            // A wrong drink wins even if the requested one shows up alongside it.
            if (oth_hit) begin
               state_nxt = S_DONE;
               ok_nxt    = 1'b0;
               tmo_nxt   = 1'b0;
            end else if (req_hit) begin
               state_nxt = S_DONE;
               ok_nxt    = 1'b1;
            end else if (t_zero) begin
               state_nxt = S_DONE;
               tmo_nxt   = 1'b1;
            end else begin
               t_tick = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         rem      <= 4'd0;
         ok_q     <= 1'b0;
         tmo_q    <= 1'b0;
         bus.c05  <= 1'b0;
         bus.c10  <= 1'b0;
         bus.sel  <= 2'b00;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state    <= state_nxt;
         rem      <= rem_nxt;
         ok_q     <= ok_nxt;
         tmo_q    <= tmo_nxt;
         bus.c10  <= (state_nxt == S_COIN) && (rem_nxt >= 4'd2);
         bus.c05  <= (state_nxt == S_COIN) && (rem_nxt == 4'd1);
         bus.sel  <= (state_nxt == S_WAIT) ? drink_nxt : D_NONE;
         bus.busy <= (state_nxt != S_IDLE);
         bus.done <= (state_nxt == S_DONE);
      end
   end

   always_ff @(posedge clock) begin
      drink_q <= drink_nxt;
   end

   assign bus.ok  = ok_q;
   assign bus.tmo = tmo_q;

endmodule

// File: tb/tb_coffee_customer_tx.sv
// Bench for coffee_customer_tx: directed order table, reset/ignore sequences, and random
// orders checked cycle by cycle against an expected-trace model built from the pricing rules.
module tb_coffee_customer_tx;
   import coffee_pkg::*;

   localparam int GAP     = 2;
   localparam int TIMEOUT = 16;
   localparam int P_ES    = 2;
   localparam int P_ESL   = 3;
   localparam int P_CAP   = 4;

   localparam int K_RIGHT = 0;
   localparam int K_WRONG = 1;
   localparam int K_BOTH  = 2;
   localparam int K_NONE  = 3;

   typedef struct packed {
      logic       c05;
      logic       c10;
      logic [1:0] sel;
      logic       busy;
      logic       done;
      logic       ok;
      logic       tmo;
   } outs_t;

   typedef struct {
      logic [1:0] d;
      int         kind;
      int         k;
      int         sel_cyc;
      int         n10;
      int         n05;
      logic       ok;
      logic       tmo;
   } vec_t;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   coffee_customer_tx_if bus();

   coffee_customer_tx #(
      .GAP(GAP), .TIMEOUT(TIMEOUT), .P_ES(P_ES), .P_ESL(P_ESL), .P_CAP(P_CAP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input outs_t e, input string tag, input int cyc);
      outs_t a;
      a = {bus.c05, bus.c10, bus.sel, bus.busy, bus.done, bus.ok, bus.tmo};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s cyc=%0d c05,c10,sel,busy,done,ok,tmo got=%b want=%b", tag, cyc, a, e);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic raise(input logic [1:0] d);
      case (d)
         2'd1:    bus.es  = 1'b1;
         2'd2:    bus.esl = 1'b1;
         2'd3:    bus.cap = 1'b1;
         default: ;
      endcase
   endtask

   // Builds the expected per-cycle trace of one order from its price and the response,
   // drives the order, and compares every cycle until one idle cycle after DONE.
   task automatic run_order(input logic [1:0] d, input int kind, input int k, input bit noise,
                            input string tag, output int sel_cyc, output int n10,
                            output int n05, output logic r_ok, output logic r_tmo);
      outs_t      exp[$];
      outs_t      p;
      int         pr, e10, e05, wstart, wlen;
      logic [1:0] other;
      pr  = (d == 2'd1) ? P_ES : (d == 2'd2) ? P_ESL : P_CAP;
      e10 = pr / 2;
      e05 = pr % 2;
      for (int i = 0; i < e10 + e05; i++) begin
         p = '0;
         p.busy = 1'b1;
         if (i < e10) p.c10 = 1'b1;
         else         p.c05 = 1'b1;
         exp.push_back(p);
         p = '0;
         p.busy = 1'b1;
         for (int g = 0; g < GAP; g++) exp.push_back(p);
      end
      wstart = exp.size();
      wlen   = (kind == K_NONE) ? TIMEOUT : k + 1;
      p = '0;
      p.busy = 1'b1;
      p.sel  = d;
      for (int w = 0; w < wlen; w++) exp.push_back(p);
      p = '0;
      p.busy = 1'b1;
      p.done = 1'b1;
      p.ok   = (kind == K_RIGHT);
      p.tmo  = (kind == K_NONE);
      exp.push_back(p);
      p.busy = 1'b0;
      p.done = 1'b0;
      exp.push_back(p);

      other = (d == 2'd3) ? 2'd1 : d + 2'd1;
      bus.start = 1'b1;
      bus.drink = d;
      tick();
      bus.start = 1'b0;
      sel_cyc = 0;
      n10 = 0;
      n05 = 0;
      r_ok = 1'b0;
      r_tmo = 1'b0;
      for (int i = 0; i < exp.size(); i++) begin
         chk(exp[i], tag, i + 1);
         if (sel_cyc == 0 && bus.sel != 2'b00) sel_cyc = i + 1;
         n10 += int'(bus.c10);
         n05 += int'(bus.c05);
         r_ok  = bus.ok;
         r_tmo = bus.tmo;
         bus.es  = 1'b0;
         bus.esl = 1'b0;
         bus.cap = 1'b0;
         if (kind != K_NONE && i == wstart + k) begin
            if (kind != K_WRONG) raise(d);
            if (kind != K_RIGHT) raise(other);
         end
         bus.start = (noise && i < exp.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.drink = 2'($urandom);
         tick();
      end
      bus.es  = 1'b0;
      bus.esl = 1'b0;
      bus.cap = 1'b0;
   endtask

   initial begin
      vec_t       tbl[7];
      outs_t      zero_o;
      outs_t      p;
      int         sc, c10n, c05n;
      logic       rok, rtmo;

      tbl[0] = '{2'd1, K_RIGHT, 0,  4, 1, 0, 1'b1, 1'b0};
      tbl[1] = '{2'd2, K_RIGHT, 2,  7, 1, 1, 1'b1, 1'b0};
      tbl[2] = '{2'd3, K_RIGHT, 5,  7, 2, 0, 1'b1, 1'b0};
      tbl[3] = '{2'd1, K_NONE,  0,  4, 1, 0, 1'b0, 1'b1};
      tbl[4] = '{2'd3, K_WRONG, 1,  7, 2, 0, 1'b0, 1'b0};
      tbl[5] = '{2'd2, K_BOTH,  15, 7, 1, 1, 1'b0, 1'b0};
      tbl[6] = '{2'd1, K_RIGHT, 15, 4, 1, 0, 1'b1, 1'b0};

      total = 0;
      bad   = 0;
      zero_o = '0;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.drink = 2'b00;
      bus.es  = 1'b0;
      bus.esl = 1'b0;
      bus.cap = 1'b0;
      tick();
      tick();
      chk(zero_o, "reset", 0);
      reset = 1'b0;
      tick();
      chk(zero_o, "post_reset", 0);

      for (int v = 0; v < 7; v++) begin
         run_order(tbl[v].d, tbl[v].kind, tbl[v].k, 1'b0, $sformatf("tbl%0d", v),
                   sc, c10n, c05n, rok, rtmo);
         chk_int($sformatf("tbl%0d_sel_cycle", v), sc, tbl[v].sel_cyc);
         chk_int($sformatf("tbl%0d_n10", v), c10n, tbl[v].n10);
         chk_int($sformatf("tbl%0d_n05", v), c05n, tbl[v].n05);
         chk_int($sformatf("tbl%0d_ok", v), int'(rok), int'(tbl[v].ok));
         chk_int($sformatf("tbl%0d_tmo", v), int'(rtmo), int'(tbl[v].tmo));
      end

      // Reset in the second cycle of a cappuccino order aborts it.
      bus.start = 1'b1;
      bus.drink = 2'd3;
      tick();
      bus.start = 1'b0;
      p = '0;
      p.c10  = 1'b1;
      p.busy = 1'b1;
      chk(p, "rst_mid_coin", 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk(zero_o, "rst_mid_clear", 3);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk(zero_o, "rst_mid_quiet", 4 + i);
      end

      // start with drink 00 is ignored.
      bus.start = 1'b1;
      bus.drink = 2'b00;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk(zero_o, "start_none_ignored", i + 1);
         tick();
      end

      for (int r = 0; r < 40; r++) begin
         run_order(2'($urandom_range(1, 3)), $urandom_range(0, 3),
                   $urandom_range(0, TIMEOUT - 1), 1'b1, $sformatf("rand%0d", r),
                   sc, c10n, c05n, rok, rtmo);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
